conv_encoder_sys: RTL
=====================

Name: conv_encoder_sys

Overview:
- Rate-1/2 feedforward convolutional encoder that sits directly upstream of decoder_sys and drives its 2-bit `encoded_bits` input.
- Constraint length K is selectable from 3 to 7 with the same `choose_constraint_length` encoding the decoder uses.
- Accepts a message bit-serially through a valid/ready handshake.
- After the last message bit it appends K-1 zero tail bits, so the decoder trellis terminates in state 0.

Parameters:
MAX_K, 7, largest supported constraint length; sets the shift-register width (MAX_K-1 state bits).

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  synchronous, active-high reset.
choose_constraint_length  input  3  K select; value = K; valid range 3..7; sampled only on an accepted start.
start  input  1  begin a new frame; honoured only in IDLE.
data_in  input  1  message bit.
data_valid  input  1  data_in is valid.
data_last  input  1  qualifies data_in as the final message bit; meaningful only when data_valid=1.
data_ready  output  1  encoder accepts data_in this cycle.
encoded_bits  output  2  [1]=g0 output, [0]=g1 output; registered.
encoded_valid  output  1  encoded_bits holds a new symbol this cycle.
busy  output  1  high in RUN and FLUSH.
done  output  1  one-cycle pulse coinciding with the final tail symbol.

Behaviour:
- Reset (synchronous): on rst=1 at a clk edge:
  - FSM goes to IDLE and the state register is cleared.
  - data_ready, encoded_valid, busy and done are 0; encoded_bits is 2'b00.
  - Reset mid-frame aborts the frame with no further symbols.
- K latch:
  - On an accepted start, K_reg <= choose_constraint_length.
  - Values 0, 1 and 2 map to 3.
  - Input changes during a frame are ignored.
- Generators (octal, MSB taps the current input, LSB taps the oldest state bit):
  - K=3: 7,5
  - K=4: 15,17
  - K=5: 23,35
  - K=6: 53,75
  - K=7: 171,133
- Encoding rule:
  - Window w = {bit, s[0..K-2]}, where s[0] is the most recent previous bit.
  - g0out = XOR(w & g0) and g1out = XOR(w & g1), using only the low K bits of w.
  - After encoding, shift: s[0] <= bit, s[i] <= s[i-1].
  - State bits at index K-1 and above are unused and held at 0.
- FSM states IDLE, RUN, FLUSH:
  - IDLE:
    - data_ready=0, busy=0.
    - On start=1: clear state, latch K, go to RUN.
    - data_valid is ignored in IDLE, including when it coincides with start.
  - RUN:
    - data_ready=1, busy=1.
    - On data_valid=1: encode data_in.
    - If data_last=1 as well: load tail_cnt <= K_reg-1 and go to FLUSH.
    - Cycles with data_valid=0 emit nothing.
  - FLUSH:
    - data_ready=0, busy=1.
    - Each cycle: encode bit 0 and decrement tail_cnt.
    - On the cycle that encodes the final tail bit (tail_cnt=1): assert done with that symbol, then go to IDLE.
- Timing:
  - Latency: the symbol for a bit encoded on edge n appears on encoded_bits with encoded_valid=1 during the cycle after edge n (1 cycle).
  - Tail symbols are back-to-back, exactly K-1 per frame.
  - Total symbols per frame = message length + K-1.
- Output when idle: when encoded_valid=0, encoded_bits=2'b00.
- Start handling: start in RUN or FLUSH is ignored. A start in the cycle immediately after done is accepted, giving back-to-back frames.
- Single-bit frame: data_valid=1 and data_last=1 on the first RUN cycle is legal.

Test Plan:
- K=3: start; bits 1,0,1,1 with last on the 4th -> encoded_bits 11,10,00,01 then tail 01,11; encoded_valid high 6 cycles; done on the 6th; busy drops the next cycle.
- K=7: single bit 1 with last -> 11,10,11,11,00,01,11 (7 symbols); done with the 7th.
- Handshake gaps, K=3: same bits as the first test with data_valid low for 2 cycles between each bit -> identical symbol sequence; encoded_valid low during gaps, encoded_bits=00 in gaps.
- choose_constraint_length=3'b001 -> behaves as K=3 (2 tail symbols). Changing select to 7 mid-frame -> still 2 tail symbols.
- rst asserted in FLUSH -> next cycle all outputs 0, FSM IDLE. New frame K=3 with bit 1 and last -> 11,10,11 (state cleared).
- start asserted in RUN is ignored. start on the cycle after done begins a new frame; its first symbol equals the fresh-state result (bit 1 -> 11).

Source files
------------

// File: rtl/conv_encoder_sys.sv
// rtl/conv_encoder_sys.sv - rate-1/2 feedforward convolutional encoder, K=3..7, zero-tail terminated
module conv_encoder_sys #(
  parameter int MAX_K = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] choose_constraint_length,
  input  logic       start,
  input  logic       data_in,
  input  logic       data_valid,
  input  logic       data_last,
  output logic       data_ready,
  output logic [1:0] encoded_bits,
  output logic       encoded_valid,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]       state;
  logic [2:0]       k_reg;
  logic [2:0]       tail_cnt;
  logic [MAX_K-2:0] sr;
  logic [MAX_K-2:0] sr_next;
  logic [MAX_K-1:0] g0;
  logic [MAX_K-1:0] g1;
  logic [MAX_K-1:0] msb_pos;
  logic [MAX_K-1:0] win;
  logic             enc_bit;
  logic [1:0]       sym;

  always_comb begin
    g0 = MAX_K'(7'o7);
    g1 = MAX_K'(7'o5);
    case (k_reg)
      3'd4: begin g0 = MAX_K'(7'o15);  g1 = MAX_K'(7'o17);  end
      3'd5: begin g0 = MAX_K'(7'o23);  g1 = MAX_K'(7'o35);  end
      3'd6: begin g0 = MAX_K'(7'o53);  g1 = MAX_K'(7'o75);  end
      3'd7: begin g0 = MAX_K'(7'o171); g1 = MAX_K'(7'o133); end
      default: begin g0 = MAX_K'(7'o7); g1 = MAX_K'(7'o5); end
    endcase
  end

  // sr[K-2] holds the most recent bit and sr[0] the oldest, so the window is sr with the new bit on top.
  assign msb_pos = MAX_K'(1) << (k_reg - 3'd1);
  assign enc_bit = (state == RUN) ? data_in : 1'b0;
  assign win     = {1'b0, sr} | (enc_bit ? msb_pos : '0);
  assign sym     = {^(win & g0), ^(win & g1)};
  assign sr_next = (sr >> 1) | (enc_bit ? msb_pos[MAX_K-1:1] : '0);

  assign data_ready = (state == RUN);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      k_reg         <= 3'd3;
      tail_cnt      <= 3'd0;
      sr            <= '0;
      encoded_bits  <= 2'b00;
      encoded_valid <= 1'b0;
      done          <= 1'b0;
    end else begin
      encoded_bits  <= 2'b00;
      encoded_valid <= 1'b0;
      done          <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sr    <= '0;
            k_reg <= (choose_constraint_length < 3'd3) ? 3'd3 : choose_constraint_length;
            state <= RUN;
          end
        end
        RUN: begin
          if (data_valid) begin
            sr            <= sr_next;
            encoded_bits  <= sym;
            encoded_valid <= 1'b1;
            if (data_last) begin
              tail_cnt <= k_reg - 3'd1;
              state    <= FLUSH;
            end
          end
        end
        FLUSH: begin
          sr            <= sr_next;
          encoded_bits  <= sym;
          encoded_valid <= 1'b1;
          tail_cnt      <= tail_cnt - 3'd1;
          if (tail_cnt == 3'd1) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
